// File: rtl/ceff_pkg.sv
// ceff_pkg: shared types and helpers for the ceff_pipe elastic register pipeline.
//   STAT_W      : width of the optional statistics counters.
//   ceff_stat_t : statistics counter type.
//   occ_width() : width of an occupancy count able to hold 0..depth.
package ceff_pkg;

  localparam int STAT_W = 32;

  typedef logic [STAT_W-1:0] ceff_stat_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ceff_stage.sv
// ceff_stage: one valid/data register pair of the ceff_pipe pipeline.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (clears valid; clears
//                  data too when CLEAR_DATA=1).
//   flush        : synchronous clear of the valid bit; data untouched.
//   adv_i        : stage advances this cycle (already qualified by enable).
//   src_valid_i  : valid of the upstream source (input port or previous stage).
//   src_data_i   : payload of the upstream source.
//   valid_o      : registered stage valid.
//   data_o       : registered stage payload.
module ceff_stage #(
  parameter int WIDTH      = 32,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             adv_i,
  input  logic             src_valid_i,
  input  logic [WIDTH-1:0] src_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             v_q;
  logic [WIDTH-1:0] d_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= 1'b0;
    end else if (flush) begin
      v_q <= 1'b0;
    end else if (adv_i) begin
      v_q <= src_valid_i;
    end
  end

  // Data only loads when a real beat arrives, so a bubble passing through
  // leaves the previous payload in place (saves toggling).
  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_DATA) begin
        d_q <= '0;
      end
    end else if (!flush && adv_i && src_valid_i) begin
      d_q <= src_data_i;
    end
  end

  assign valid_o = v_q;
  assign data_o  = d_q;

endmodule

// File: rtl/ceff_pipe.sv
// ceff_pipe: DEPTH-stage elastic register pipeline with valid/ready on both
// sides, global freeze enable, synchronous flush and bubble collapsing.
// Optional statistics counters are compiled in when CEFF_PIPE_STATS_EN is
// defined.
//
// Handshake: a beat transfers on a side in any cycle where that side's valid
// and ready are both 1. Valid never depends on ready on the same side; the
// upstream in_ready is combinational from out_ready through the advance chain.
// While enable=0, flush=1 or reset=1, in_ready and out_valid are forced to 0.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset.
//   enable              : 0 freezes every stage.
//   flush               : clears all stage valids; input not accepted.
//   in_valid/in_data    : upstream beat.
//   in_ready            : pipeline accepts a beat this cycle.
//   out_valid/out_data  : beat at the last stage (out_data always driven).
//   out_ready           : downstream accepts.
//   occupancy           : number of valid stages.
//   stat_in_cnt, stat_out_cnt, stat_stall_cnt (CEFF_PIPE_STATS_EN only):
//                         saturating transfer/stall counters, reset-cleared.
module ceff_pipe
  import ceff_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 2,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [occ_width(DEPTH)-1:0]  occupancy
`ifdef CEFF_PIPE_STATS_EN
  ,
  output ceff_stat_t                   stat_in_cnt,
  output ceff_stat_t                   stat_out_cnt,
  output ceff_stat_t                   stat_stall_cnt
`endif
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [WIDTH-1:0] d     [DEPTH];
  logic [OCC_W-1:0] occ_sum;
  logic             run;

  assign run = !reset && enable && !flush;

  // A stage advances when it is empty or its successor advances; this is what
  // lets bubbles collapse behind a stalled tail.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = !v[DEPTH-1] || out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = !v[k] || adv[k+1];
    end
  end

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_src_in
        assign src_v[k] = in_valid;
        assign src_d[k] = in_data;
      end else begin : g_src_prev
        assign src_v[k] = v[k-1];
        assign src_d[k] = d[k-1];
      end

      ceff_stage #(
        .WIDTH      (WIDTH),
        .CLEAR_DATA (CLEAR_DATA)
      ) u_stage (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .adv_i       (enable && adv[k]),
        .src_valid_i (src_v[k]),
        .src_data_i  (src_d[k]),
        .valid_o     (v[k]),
        .data_o      (d[k])
      );
    end
  endgenerate

  assign in_ready  = run && adv[0];
  assign out_valid = run && v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_sum = occ_sum + OCC_W'(v[i]);
    end
  end

  assign occupancy = reset ? '0 : occ_sum;

`ifdef CEFF_PIPE_STATS_EN
  localparam ceff_stat_t STAT_MAX = '1;

  ceff_stat_t in_cnt_q, in_cnt_d;
  ceff_stat_t out_cnt_q, out_cnt_d;
  ceff_stat_t stall_cnt_q, stall_cnt_d;

  // Stall counts a held tail beat even in a flush cycle; flush never clears
  // the counters.
  always_comb begin
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (in_valid && in_ready && in_cnt_q != STAT_MAX) begin
      in_cnt_d = in_cnt_q + ceff_stat_t'(1);
    end
    if (out_valid && out_ready && out_cnt_q != STAT_MAX) begin
      out_cnt_d = out_cnt_q + ceff_stat_t'(1);
    end
    if (v[DEPTH-1] && enable && !out_ready && stall_cnt_q != STAT_MAX) begin
      stall_cnt_d = stall_cnt_q + ceff_stat_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_in_cnt    = in_cnt_q;
  assign stat_out_cnt   = out_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ceff_pipe.sv
// tb_ceff_pipe: self-checking bench for ceff_pipe (DEPTH=3, WIDTH=8,
// CLEAR_DATA=1). A beat-level reference model (queue of beats, each with its
// stage position) predicts the handshake outputs every cycle; a scoreboard
// queue checks the order of emitted payloads. Stats ports and checks are
// included when CEFF_PIPE_STATS_EN is defined.
module tb_ceff_pipe;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int OW = $clog2(D + 1);

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          flush;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [OW-1:0] occupancy;
`ifdef CEFF_PIPE_STATS_EN
  logic [31:0]   stat_in_cnt;
  logic [31:0]   stat_out_cnt;
  logic [31:0]   stat_stall_cnt;
`endif

  always #5 clk = ~clk;

  ceff_pipe #(
    .WIDTH      (W),
    .DEPTH      (D),
    .CLEAR_DATA (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef CEFF_PIPE_STATS_EN
    ,
    .stat_in_cnt    (stat_in_cnt),
    .stat_out_cnt   (stat_out_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [W-1:0] data;
    int           pos;
  } beat_t;

  beat_t        mdl_q[$];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [31:0]  m_in_cnt = 0;
  logic [31:0]  m_out_cnt = 0;
  logic [31:0]  m_stall_cnt = 0;

  bit s_in_fire, s_out_fire, s_last_full, s_exp_ir, s_exp_ov;
  int s_newpos[D];

  // Predict this cycle's outputs from the beat list, compare, and remember
  // where every beat goes at the coming edge.
  task automatic sample();
    int           limit;
    int           exp_occ;
    logic [W-1:0] e;
    @(negedge clk);
    s_last_full = (mdl_q.size() > 0) && (mdl_q[0].pos == D - 1);
    limit = D;
    for (int i = 0; i < mdl_q.size(); i++) begin
      if (mdl_q[i].pos == D - 1 && out_ready) s_newpos[i] = D;
      else if (mdl_q[i].pos + 1 < limit)       s_newpos[i] = mdl_q[i].pos + 1;
      else                                     s_newpos[i] = mdl_q[i].pos;
      limit = s_newpos[i];
    end
    s_exp_ir   = !reset && enable && !flush && (limit > 0);
    s_exp_ov   = !reset && enable && !flush && s_last_full;
    s_in_fire  = s_exp_ir && in_valid;
    s_out_fire = s_exp_ov && out_ready;
    exp_occ    = reset ? 0 : mdl_q.size();

    checks++;
    if (in_ready !== s_exp_ir) begin
      errors++;
      $display("FAIL model_in_ready: got %b expected %b at %0t", in_ready, s_exp_ir, $time);
    end
    checks++;
    if (out_valid !== s_exp_ov) begin
      errors++;
      $display("FAIL model_out_valid: got %b expected %b at %0t", out_valid, s_exp_ov, $time);
    end
    checks++;
    if (occupancy !== OW'(exp_occ)) begin
      errors++;
      $display("FAIL model_occupancy: got %0d expected %0d at %0t", occupancy, exp_occ, $time);
    end
    if (s_exp_ov) begin
      checks++;
      if (out_data !== mdl_q[0].data) begin
        errors++;
        $display("FAIL model_out_data: got %h expected %h at %0t", out_data, mdl_q[0].data, $time);
      end
    end
    if (out_valid === 1'b1 && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_beat: got %h expected no beat at %0t", out_data, $time);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL sb_order: got %h expected %h at %0t", out_data, e, $time);
        end
      end
    end
`ifdef CEFF_PIPE_STATS_EN
    checks++;
    if (stat_in_cnt !== m_in_cnt || stat_out_cnt !== m_out_cnt || stat_stall_cnt !== m_stall_cnt) begin
      errors++;
      $display("FAIL model_stats: got %0d/%0d/%0d expected %0d/%0d/%0d at %0t",
               stat_in_cnt, stat_out_cnt, stat_stall_cnt, m_in_cnt, m_out_cnt, m_stall_cnt, $time);
    end
`endif
  endtask

  // Apply the clock edge to the model, then release inputs for driving.
  task automatic tick();
    beat_t b;
    @(posedge clk);
    if (reset) begin
      mdl_q.delete();
      exp_q.delete();
      m_in_cnt    = 0;
      m_out_cnt   = 0;
      m_stall_cnt = 0;
    end else begin
      if (s_in_fire)  m_in_cnt++;
      if (s_out_fire) m_out_cnt++;
      if (s_last_full && enable && !out_ready) m_stall_cnt++;
      if (flush) begin
        mdl_q.delete();
        exp_q.delete();
      end else if (enable) begin
        for (int i = 0; i < mdl_q.size(); i++) begin
          b = mdl_q[i];
          b.pos = s_newpos[i];
          mdl_q[i] = b;
        end
        if (mdl_q.size() > 0 && mdl_q[0].pos == D) void'(mdl_q.pop_front());
        if (s_in_fire) begin
          b.data = in_data;
          b.pos  = 0;
          mdl_q.push_back(b);
          exp_q.push_back(in_data);
        end
      end
    end
    #1;
  endtask

  task automatic run_cycle();
    sample();
    tick();
  endtask

  task automatic drive(input bit iv, input logic [W-1:0] dat, input bit ordy);
    in_valid  = iv;
    in_data   = dat;
    out_ready = ordy;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; flush = 1'b0;
    drive(1'b1, 8'hA5, 1'b1);
    repeat (2) begin
      sample();
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_ready: got %b expected 0", in_ready);
      end
      tick();
    end
    sample();
    checks++;
    if (out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_out_data: got %h expected 00", out_data);
    end
    tick();
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    sample();
    checks++;
    if (in_ready !== 1'b1 || occupancy !== 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ir=%b occ=%0d ov=%b expected ir=1 occ=0 ov=0",
               in_ready, occupancy, out_valid);
    end
    tick();
  endtask

  task automatic test_latency();
    logic [W-1:0] beats[3];
    int peak;
    bit exp_v;
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
    peak = 0;
    for (int c = 0; c < 8; c++) begin
      drive(c < 3, (c < 3) ? beats[c] : W'($urandom_range(0, 255)), 1'b1);
      sample();
      if (int'(occupancy) > peak) peak = int'(occupancy);
      exp_v = (c >= 3 && c <= 5);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL latency_valid: cycle %0d got %b expected %b", c, out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (out_data !== beats[c-3]) begin
          errors++;
          $display("FAIL latency_data: cycle %0d got %h expected %h", c, out_data, beats[c-3]);
        end
      end
      tick();
    end
    checks++;
    if (peak != 3) begin
      errors++;
      $display("FAIL latency_peak_occ: got %0d expected 3", peak);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] vals[5];
    logic [W-1:0] got[$];
    int acc;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, vals[acc], 1'b0);
      sample();
      if (in_ready === 1'b1) acc++;
      tick();
    end
    checks++;
    if (acc != 3) begin
      errors++;
      $display("FAIL bp_accepted: got %0d expected 3", acc);
    end
    drive(1'b1, vals[3], 1'b0);
    sample();
    checks++;
    if (in_ready !== 1'b0 || occupancy !== 3) begin
      errors++;
      $display("FAIL bp_full: got ir=%b occ=%0d expected ir=0 occ=3", in_ready, occupancy);
    end
    tick();
    drive(1'b1, vals[3], 1'b1);
    sample();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL bp_swap: got ir=%b ov=%b od=%h expected ir=1 ov=1 od=11",
               in_ready, out_valid, out_data);
    end
    tick();
    drive(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 8; c++) begin
      sample();
      if (out_valid === 1'b1) got.push_back(out_data);
      tick();
    end
    checks++;
    if (got.size() != 3 || got[0] !== 8'h22 || got[1] !== 8'h33 || got[2] !== 8'h44) begin
      errors++;
      $display("FAIL bp_drain: got %0d beats, expected 22 33 44", got.size());
    end
  endtask

  task automatic test_bubble();
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = W'($urandom_range(0, 255));
    b = W'($urandom_range(0, 255));
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      drive(1'b1, a, 1'b0);
      else if (c == 3) drive(1'b1, b, 1'b0);
      else             drive(1'b0, 8'h00, 1'b0);
      run_cycle();
    end
    drive(1'b0, 8'h00, 1'b0);
    sample();
    checks++;
    if (occupancy !== 2 || out_valid !== 1'b1 || out_data !== a || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bubble_collapse: got occ=%0d ov=%b od=%h ir=%b expected occ=2 ov=1 od=%h ir=1",
               occupancy, out_valid, out_data, in_ready, a);
    end
    tick();
    drive(1'b0, 8'h00, 1'b1);
    repeat (6) run_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bubble_drain: got %0d beats left expected 0", exp_q.size());
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, W'($urandom_range(0, 255)), 1'b0);
      run_cycle();
    end
    drive(1'b1, 8'hEE, 1'b1);
    flush = 1'b1;
    sample();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_gate: got ir=%b ov=%b expected 0 0", in_ready, out_valid);
    end
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    sample();
    checks++;
    if (occupancy !== 0) begin
      errors++;
      $display("FAIL flush_occ: got %0d expected 0", occupancy);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      sample();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_ghost: got ov=%b od=%h expected no beat", out_valid, out_data);
      end
      tick();
    end
  endtask

  task automatic test_freeze();
    logic [OW-1:0] occ0;
    occ0 = '0;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, W'($urandom_range(0, 255)), 1'b1);
      run_cycle();
    end
    enable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, W'($urandom_range(0, 255)), 1'b1);
      sample();
      if (c == 0) occ0 = occupancy;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || occupancy !== occ0 || occ0 !== 2) begin
        errors++;
        $display("FAIL freeze_hold: cycle %0d got ir=%b ov=%b occ=%0d expected ir=0 ov=0 occ=2",
                 c, in_ready, out_valid, occupancy);
      end
      tick();
    end
    enable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, W'($urandom_range(0, 255)), 1'b1);
      run_cycle();
    end
    drive(1'b0, 8'h00, 1'b1);
    repeat (D + 2) run_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL freeze_resume: got %0d beats left expected 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      flush  = ($urandom_range(0, 29) == 0);
      drive($urandom_range(0, 1) == 1, W'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
      run_cycle();
    end
    enable = 1'b1;
    flush  = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    repeat (D + 2) run_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got %0d beats left expected 0", exp_q.size());
    end
  endtask

`ifdef CEFF_PIPE_STATS_EN
  task automatic test_stats();
    int sent, recv, stalls, budget;
    bit ordy;
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    run_cycle();
    reset = 1'b0;
    sent = 0; recv = 0; stalls = 0; budget = 0;
    while (recv < 10 && budget < 80) begin
      ordy = 1'b1;
      if (stalls < 4 && mdl_q.size() > 0 && mdl_q[0].pos == D - 1) begin
        ordy = 1'b0;
        stalls++;
      end
      drive(sent < 10, W'($urandom_range(0, 255)), ordy);
      sample();
      if (in_valid && in_ready === 1'b1) sent++;
      if (out_valid === 1'b1 && out_ready) recv++;
      tick();
      budget++;
    end
    drive(1'b0, 8'h00, 1'b1);
    run_cycle();
    sample();
    checks++;
    if (budget >= 80 || stat_in_cnt !== 10 || stat_out_cnt !== 10 || stat_stall_cnt !== 4) begin
      errors++;
      $display("FAIL stats_counts: got %0d/%0d/%0d expected 10/10/4",
               stat_in_cnt, stat_out_cnt, stat_stall_cnt);
    end
    tick();
    flush = 1'b1;
    run_cycle();
    flush = 1'b0;
    sample();
    checks++;
    if (stat_in_cnt !== 10 || stat_out_cnt !== 10 || stat_stall_cnt !== 4) begin
      errors++;
      $display("FAIL stats_flush: got %0d/%0d/%0d expected 10/10/4",
               stat_in_cnt, stat_out_cnt, stat_stall_cnt);
    end
    tick();
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    sample();
    checks++;
    if (stat_in_cnt !== 0 || stat_out_cnt !== 0 || stat_stall_cnt !== 0) begin
      errors++;
      $display("FAIL stats_reset: got %0d/%0d/%0d expected 0/0/0",
               stat_in_cnt, stat_out_cnt, stat_stall_cnt);
    end
    tick();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_bubble();
    test_flush();
    test_freeze();
    test_random();
`ifdef CEFF_PIPE_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
